// File: rtl/mips_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_div_pkg
// Description : Shared FSM encodings and handshake constants for mips_div.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_div_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage : mips_div_pkg
`default_nettype wire

// File: rtl/mips_div_step.sv
`default_nettype none
// ============================================================================
// Module      : mips_div_step
// Description : One combinational restoring-division step (shift/subtract/select).
// Revision    : 1.0 - initial release
// ============================================================================
module mips_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_rem,
    input  logic              i_bit,
    input  logic [DATA_W-1:0] i_dsor,
    output logic [DATA_W-1:0] o_rem,
    output logic              o_q_bit
);

    logic [DATA_W:0]   w_shift;
    logic [DATA_W-1:0] w_diff_lo;

    assign w_shift   = {i_rem, i_bit};
    // Low bits of the modular difference equal the true difference whenever it is non-negative.
    assign w_diff_lo = w_shift[DATA_W-1:0] - i_dsor;
    assign o_q_bit   = (w_shift >= {1'b0, i_dsor});
    assign o_rem     = o_q_bit ? w_diff_lo : w_shift[DATA_W-1:0];

endmodule : mips_div_step
`default_nettype wire

// File: rtl/mips_div.sv
`default_nettype none
// ============================================================================
// Module      : mips_div
// Description : Multi-cycle signed/unsigned restoring divider with start/annul
//               handshake. Optional divide-by-zero detection: MIPS_DIV_ZERO_DETECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_div
    import mips_div_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  div_zero_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] c_last_step = CNT_W'(DATA_W - 1);
`ifdef MIPS_DIV_ZERO_DETECT_EN
    localparam logic c_zero_detect = 1'b1;
`else
    localparam logic c_zero_detect = 1'b0;
`endif

    div_state_e            r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0]     r_rem, w_rem_nxt;
    logic [DATA_W-1:0]     r_dvd, w_dvd_nxt;
    logic [DATA_W-1:0]     r_dsor, w_dsor_nxt;
    logic                  r_neg_q, w_neg_q_nxt;
    logic                  r_neg_r, w_neg_r_nxt;
    logic [2*DATA_W-1:0]   r_result, w_result_nxt;
    logic                  r_ready, w_ready_nxt;
    logic                  r_div_zero, w_div_zero_nxt;

    logic [DATA_W-1:0]     w_op1_abs, w_op2_abs;
    logic                  w_zero_start;
    logic [DATA_W-1:0]     w_step_rem;
    logic                  w_step_q;
    logic [DATA_W-1:0]     w_quot_new;

    assign w_op1_abs    = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign w_op2_abs    = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    assign w_zero_start = c_zero_detect && (opdata2_i == '0);

    // The dividend register shifts out its MSB each step and collects quotient bits at the LSB.
    mips_div_step #(.DATA_W(DATA_W)) u_step (
        .i_rem   (r_rem),
        .i_bit   (r_dvd[DATA_W-1]),
        .i_dsor  (r_dsor),
        .o_rem   (w_step_rem),
        .o_q_bit (w_step_q)
    );

    assign w_quot_new = {r_dvd[DATA_W-2:0], w_step_q};

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_rem_nxt      = r_rem;
        w_dvd_nxt      = r_dvd;
        w_dsor_nxt     = r_dsor;
        w_neg_q_nxt    = r_neg_q;
        w_neg_r_nxt    = r_neg_r;
        w_result_nxt   = r_result;
        w_ready_nxt    = r_ready;
        w_div_zero_nxt = r_div_zero;
        case (r_state)
            DIV_FREE: begin
                if (start_i == DivStart) begin
                    w_dvd_nxt   = w_op1_abs;
                    w_dsor_nxt  = w_op2_abs;
                    w_rem_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_neg_q_nxt = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                    w_neg_r_nxt = signed_div_i & opdata1_i[DATA_W-1];
                    w_state_nxt = w_zero_start ? DIV_BY_ZERO : DIV_ON;
                end
            end
            DIV_BY_ZERO: begin
                w_state_nxt    = DIV_END;
                w_result_nxt   = '0;
                w_ready_nxt    = DivResultReady;
                w_div_zero_nxt = c_zero_detect;
            end
            DIV_ON: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                w_rem_nxt = w_step_rem;
                w_dvd_nxt = w_quot_new;
                // Last step registers the sign-corrected result directly so ready lands on edge DATA_W.
                if (r_cnt == c_last_step) begin
                    w_state_nxt  = DIV_END;
                    w_ready_nxt  = DivResultReady;
                    w_result_nxt = {(r_neg_r ? -w_step_rem : w_step_rem),
                                    (r_neg_q ? -w_quot_new : w_quot_new)};
                end
            end
            DIV_END: begin
                if (start_i == DivStop) begin
                    w_state_nxt    = DIV_FREE;
                    w_ready_nxt    = DivResultNotReady;
                    w_result_nxt   = '0;
                    w_div_zero_nxt = 1'b0;
                end
            end
            default: w_state_nxt = DIV_FREE;
        endcase
        if (annul_i) begin
            w_state_nxt    = DIV_FREE;
            w_cnt_nxt      = '0;
            w_ready_nxt    = DivResultNotReady;
            w_result_nxt   = '0;
            w_div_zero_nxt = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state    <= DIV_FREE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_dvd      <= '0;
            r_dsor     <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_result   <= '0;
            r_ready    <= DivResultNotReady;
            r_div_zero <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rem      <= w_rem_nxt;
            r_dvd      <= w_dvd_nxt;
            r_dsor     <= w_dsor_nxt;
            r_neg_q    <= w_neg_q_nxt;
            r_neg_r    <= w_neg_r_nxt;
            r_result   <= w_result_nxt;
            r_ready    <= w_ready_nxt;
            r_div_zero <= w_div_zero_nxt;
        end
    end

    assign result_o   = r_result;
    assign ready_o    = r_ready;
    assign div_zero_o = c_zero_detect & r_div_zero;

endmodule : mips_div
`default_nettype wire

// File: tb/tb_mips_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_div
// Description : Directed self-checking bench for mips_div (DATA_W = 32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_div;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        div_zero_o;

    int checks   = 0;
    int failures = 0;

    mips_div #(.DATA_W(32)) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .div_zero_o   (div_zero_o)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a request and let the sampling edge (edge 0) pass.
    task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        tick();
    endtask

    task automatic wait_result(input string tag, input logic [31:0] q, input logic [31:0] r);
        repeat (31) tick();
        check({tag, "_not_ready_e31"}, {63'd0, ready_o}, 64'd0);
        tick();
        check({tag, "_ready_e32"}, {63'd0, ready_o}, 64'd1);
        check({tag, "_result"}, result_o, {r, q});
        check({tag, "_div_zero"}, {63'd0, div_zero_o}, 64'd0);
    endtask

    task automatic release_op(input string tag);
        start_i = 1'b0;
        tick();
        check({tag, "_ready_clear"}, {63'd0, ready_o}, 64'd0);
        check({tag, "_result_clear"}, result_o, 64'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("reset_ready", {63'd0, ready_o}, 64'd0);
        check("reset_result", result_o, 64'd0);
        check("reset_div_zero", {63'd0, div_zero_o}, 64'd0);
        Rst_n = 1'b1;
        tick();

        // Unsigned 100/7; operands and start change mid-division must be ignored
        start_op(1'b0, 32'd100, 32'd7);
        opdata1_i = 32'd999;
        opdata2_i = 32'd3;
        start_i   = 1'b0;
        repeat (4) tick();
        start_i   = 1'b1;
        repeat (27) tick();
        check("u100_7_not_ready_e31", {63'd0, ready_o}, 64'd0);
        tick();
        check("u100_7_ready_e32", {63'd0, ready_o}, 64'd1);
        check("u100_7_result", result_o, {32'd2, 32'd14});
        repeat (3) tick();
        check("u100_7_hold_ready", {63'd0, ready_o}, 64'd1);
        check("u100_7_hold_result", result_o, {32'd2, 32'd14});
        release_op("u100_7");

        // Signed -7/2 -> q=-3, r=-1
        start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_result("s_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        release_op("s_m7_2");

        // Signed 7/-2 -> q=-3, r=1
        start_op(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_result("s_7_m2", 32'hFFFF_FFFD, 32'd1);
        release_op("s_7_m2");

        // Signed -7/-2 -> q=3, r=-1
        start_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
        wait_result("s_m7_m2", 32'd3, 32'hFFFF_FFFF);
        release_op("s_m7_m2");

        // Unsigned all-ones / 1
        start_op(1'b0, 32'hFFFF_FFFF, 32'd1);
        wait_result("u_max_1", 32'hFFFF_FFFF, 32'd0);
        release_op("u_max_1");

        // Divide by zero
`ifdef MIPS_DIV_ZERO_DETECT_EN
        start_op(1'b0, 32'd5, 32'd0);
        check("dz_not_ready_e0", {63'd0, ready_o}, 64'd0);
        tick();
        check("dz_ready", {63'd0, ready_o}, 64'd1);
        check("dz_result", result_o, 64'd0);
        check("dz_flag", {63'd0, div_zero_o}, 64'd1);
        tick();
        check("dz_flag_hold", {63'd0, div_zero_o}, 64'd1);
        release_op("dz");
        check("dz_flag_clear", {63'd0, div_zero_o}, 64'd0);
`else
        start_op(1'b0, 32'd5, 32'd0);
        wait_result("dz", 32'hFFFF_FFFF, 32'd5);
        release_op("dz");
`endif

        // Annul pulsed after edge 10, seen at edge 11; no result ever appears
        start_op(1'b0, 32'd100, 32'd7);
        repeat (10) tick();
        annul_i = 1'b1;
        start_i = 1'b0;
        tick();
        annul_i = 1'b0;
        begin
            logic seen_ready;
            seen_ready = 1'b0;
            repeat (40) begin
                tick();
                seen_ready = seen_ready | ready_o;
            end
            check("annul_no_ready", {63'd0, seen_ready}, 64'd0);
        end
        check("annul_result_zero", result_o, 64'd0);

        // start and annul together in DIV_FREE: annul wins, request starts after annul drops
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd33;
        start_i      = 1'b1;
        annul_i      = 1'b1;
        repeat (3) tick();
        annul_i = 1'b0;
        tick();
        wait_result("u1000_33", 32'd30, 32'd10);
        release_op("u1000_33");

        // Asynchronous reset between edges 15 and 16
        start_op(1'b0, 32'd12345, 32'd7);
        repeat (15) tick();
        #2 Rst_n = 1'b0;
        #1;
        check("rst_mid_ready", {63'd0, ready_o}, 64'd0);
        check("rst_mid_result", result_o, 64'd0);
        start_i = 1'b0;
        tick();
        Rst_n = 1'b1;
        tick();
        start_op(1'b0, 32'd9, 32'd3);
        wait_result("u9_3", 32'd3, 32'd0);
        // Reset while the result is held clears outputs before any edge
        #2 Rst_n = 1'b0;
        #1;
        check("rst_end_ready", {63'd0, ready_o}, 64'd0);
        check("rst_end_result", result_o, 64'd0);
        start_i = 1'b0;
        tick();
        Rst_n = 1'b1;
        tick();

        // Signed most-negative / -1
        start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("s_min_m1", 32'h8000_0000, 32'd0);
        release_op("s_min_m1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mips_div
`default_nettype wire

// File: doc/mips_div.md
MIPS_DIV -- requirements
Module: mips_div

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand width in bits (>=4).
REQ-002 SHALL have port Clk  input  1  rising-edge clock.
REQ-003 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port signed_div_i  input  1  1 = two's-complement divide, 0 = unsigned.
REQ-005 SHALL have port opdata1_i  input  DATA_W  dividend.
REQ-006 SHALL have port opdata2_i  input  DATA_W  divisor.
REQ-007 SHALL have port start_i  input  1  request; held high by the pipeline until ready_o is seen.
REQ-008 SHALL have port annul_i  input  1  abort of the current operation (branch/flush).
REQ-009 SHALL have port result_o  output  2*DATA_W  {remainder, quotient}: upper half remainder, lower half quotient.
REQ-010 SHALL have port ready_o  output  1  result_o valid.
REQ-011 SHALL have port div_zero_o  output  1  divisor was zero (see REQ-027).

Function
REQ-012 SHALL implement a 4-state FSM: DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END.
REQ-013 DIV_FREE: start_i=1 and annul_i=0 SHALL latch operands and sign mode and go to DIV_ON; otherwise stay.
REQ-014 Latching SHALL store absolute values of operands when signed_div_i=1, and raw values when 0.
REQ-015 DIV_ON SHALL perform one restoring-division step per cycle: shift partial remainder left 1, subtract |divisor|, keep and set the quotient bit if non-negative, else restore and clear it.
REQ-016 An internal counter of ceil(log2(DATA_W+1)) bits SHALL count steps; on the DATA_W-th step, the FSM SHALL go to DIV_END.
REQ-017 On entering DIV_END, signed mode SHALL negate the quotient if operand signs differed and negate the remainder if the dividend was negative.
REQ-018 result_o and ready_o SHALL be registered; ready_o=1 exactly while in DIV_END.
REQ-019 Latency: ready_o SHALL rise on the DATA_W-th rising edge after the edge that sampled start_i.
REQ-020 DIV_END SHALL hold result_o and ready_o while start_i=1, and return to DIV_FREE when start_i=0.
REQ-021 On returning to DIV_FREE, ready_o SHALL clear to 0 and result_o SHALL clear to 0.
REQ-022 annul_i=1 in any state SHALL force DIV_FREE on the next edge with ready_o=0, and SHALL produce no result.
REQ-023 When start_i and annul_i are both high in DIV_FREE, annul_i SHALL win (remain DIV_FREE).
REQ-024 start_i changes while in DIV_ON SHALL be ignored; operands SHALL NOT be re-sampled until DIV_FREE.
REQ-025 Signed dividend = -2^(DATA_W-1) with divisor -1 SHALL yield quotient 2^(DATA_W-1) (bit pattern) and remainder 0, with no exception.

Reset
REQ-026 Rst_n=0 SHALL, asynchronously and in any state including mid-division, force DIV_FREE, counter 0, result_o=0, ready_o=0, div_zero_o=0.

Configuration
REQ-027 With macro MIPS_DIV_ZERO_DETECT_EN defined, divisor 0 at start SHALL go to DIV_BY_ZERO, then DIV_END on the next edge with result_o=0 and div_zero_o=1 (held with ready_o); the end-state handshake SHALL follow REQ-020 and REQ-021.
REQ-028 Without MIPS_DIV_ZERO_DETECT_EN, the DIV_BY_ZERO state SHALL be unreachable and div_zero_o tied 0; divisor 0 SHALL run the full DATA_W steps, giving unsigned quotient all-ones and remainder = |dividend|, sign-corrected per REQ-017.

Structure
REQ-029 FSM state encodings (DIV_FREE..DIV_END) and the DivResultReady/DivResultNotReady, DivStart/DivStop constants SHALL live in the shared define header used by the core.
REQ-030 The single restoring step (subtract/compare/select) SHALL be a combinational sub-module mips_div_step, instantiated once.

Verification
REQ-031 Unsigned 100/7, DATA_W=32 -> ready_o at edge 32, result_o upper=2, lower=14; held while start_i=1.
REQ-032 Signed 0xFFFFFFF9 / 2 -> lower=0xFFFFFFFD, upper=0xFFFFFFFF.
REQ-033 5/0 with the macro defined -> ready_o after 2 edges, result_o=0, div_zero_o=1; without the macro -> ready_o at edge 32, lower=0xFFFFFFFF, upper=5, div_zero_o=0.
REQ-034 annul_i pulsed at edge 10 of a division -> DIV_FREE at edge 11, ready_o never rises; a new start is then accepted and completes correctly.
REQ-035 Rst_n dropped between edges 15 and 16 -> all outputs 0 immediately; after release, 9/3 gives lower=3, upper=0.
REQ-036 Signed 0x80000000 / 0xFFFFFFFF -> lower=0x80000000, upper=0; start_i=0 in DIV_END -> ready_o=0 next edge.
